// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Holds the FSM state encoding, the word-alignment mask and the default memory size.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [31:0] WORD_ALIGN_MASK   = 32'h0000_0003;
  localparam int          DEFAULT_MEM_BYTES = 65536;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of requester-side and memory-side signals for dmem_arbiter.
// The slave modport is the arbiter's view; master is the requesters plus the memory.
interface dmem_arbiter_if;

  logic        req0, req1;
  logic        we0, we1;
  logic [31:0] adr0, adr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic        err0, err1;
  logic        busy;
  logic [31:0] mem_adr;
  logic [31:0] mem_d_in;
  logic        mem_mrd;
  logic        mem_mwr;
  logic [31:0] mem_d_out;

  modport slave (
    input  req0, req1, we0, we1, adr0, adr1, wdata0, wdata1, mem_d_out,
    output ack0, ack1, rdata0, rdata1, err0, err1, busy,
           mem_adr, mem_d_in, mem_mrd, mem_mwr
  );

  modport master (
    output req0, req1, we0, we1, adr0, adr1, wdata0, wdata1, mem_d_out,
    input  ack0, ack1, rdata0, rdata1, err0, err1, busy,
           mem_adr, mem_d_in, mem_mrd, mem_mwr
  );

endinterface

// File: rtl/dmem_arb_rr.sv
// Two-way round-robin pick: on a tie the port not granted last wins,
// otherwise the single requesting port wins.
module dmem_arb_rr (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_idx
);

  always_comb begin
    grant_valid = req0 | req1;
    grant_idx   = 1'b0;
    if (req0 && req1) begin
      grant_idx = ~last_grant;
    end else if (req1) begin
      grant_idx = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto one single-cycle data memory.
// IDLE samples and registers the winner, ACCESS drives the memory, RESP issues the ack.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_BYTES = DEFAULT_MEM_BYTES
) (
  input logic            clk,
  input logic            rst,
  dmem_arbiter_if.slave  bus
);

  localparam logic [31:0] MAX_ADR = 32'(MEM_BYTES - 4);

  state_t      state_q, state_d;
  logic        last_grant;
  logic        grant_valid, grant_idx;
  logic        sel_we, sel_legal;
  logic [31:0] sel_adr, sel_wdata;

  logic        r_we, r_port, r_bad;
  logic [31:0] r_adr, r_wdata;

  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;

  dmem_arb_rr u_rr (
    .req0        (bus.req0),
    .req1        (bus.req1),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign sel_we    = grant_idx ? bus.we1    : bus.we0;
  assign sel_adr   = grant_idx ? bus.adr1   : bus.adr0;
  assign sel_wdata = grant_idx ? bus.wdata1 : bus.wdata0;
  assign sel_legal = ((sel_adr & WORD_ALIGN_MASK) == 32'h0) && (sel_adr <= MAX_ADR);

  // NOTE: sequential state is updated only with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block is given a default before the case statement;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d      = state_q;
    bus.busy     = (state_q != IDLE);
    bus.mem_adr  = 32'h0;
    bus.mem_d_in = 32'h0;
    bus.mem_mrd  = 1'b0;
    bus.mem_mwr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d = sel_legal ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        state_d      = RESP;
        bus.mem_adr  = r_adr;
        bus.mem_d_in = r_wdata;
        bus.mem_mwr  = r_we;
        bus.mem_mrd  = ~r_we;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request capture, read-data capture and the one-cycle ack/err pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant <= 1'b1;
      r_we       <= 1'b0;
      r_port     <= 1'b0;
      r_bad      <= 1'b0;
      r_adr      <= 32'h0;
      r_wdata    <= 32'h0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      rdata0     <= 32'h0;
      rdata1     <= 32'h0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_valid) begin
            r_we       <= sel_we;
            r_adr      <= sel_adr;
            r_wdata    <= sel_wdata;
            r_port     <= grant_idx;
            r_bad      <= ~sel_legal;
            last_grant <= grant_idx;
          end
        end
        ACCESS: begin
          if (!r_we) begin
            if (r_port) rdata1 <= bus.mem_d_out;
            else        rdata0 <= bus.mem_d_out;
          end
        end
        RESP: begin
          // An illegal request never reached memory, so its read data is forced to 0.
          if (r_port) begin
            ack1 <= 1'b1;
            err1 <= r_bad;
            if (r_bad) rdata1 <= 32'h0;
          end else begin
            ack0 <= 1'b1;
            err0 <= r_bad;
            if (r_bad) rdata0 <= 32'h0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ack0   = ack0;
  assign bus.ack1   = ack1;
  assign bus.err0   = err0;
  assign bus.err1   = err1;
  assign bus.rdata0 = rdata0;
  assign bus.rdata1 = rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: drives both requesters and models a 64 KiB memory.
// Inputs change and outputs are sampled on the falling edge.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.MEM_BYTES(65536)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [0:16383];
  assign bus.mem_d_out = mem[bus.mem_adr[15:2]];
  always @(posedge clk) if (bus.mem_mwr) mem[bus.mem_adr[15:2]] <= bus.mem_d_in;

  int checks = 0;
  int errors = 0;
  int dual_ack = 0;
  int mwr_cycles = 0;
  always @(negedge clk) begin
    if (bus.ack0 && bus.ack1) dual_ack++;
    if (bus.mem_mwr) mwr_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request from the current falling edge and waits (bounded) for its ack.
  // lat counts rising edges after the sampling edge; -1 means no ack arrived.
  task automatic txn(input bit port, input bit we, input logic [31:0] adr,
                     input logic [31:0] wd, output int lat, output bit err,
                     output logic [31:0] rd, output bit saw_mrd);
    bit done = 1'b0;
    lat = -1; err = 1'b0; rd = 32'h0; saw_mrd = 1'b0;
    if (port) begin bus.req1 = 1'b1; bus.we1 = we; bus.adr1 = adr; bus.wdata1 = wd; end
    else      begin bus.req0 = 1'b1; bus.we0 = we; bus.adr0 = adr; bus.wdata0 = wd; end
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.mem_mrd) saw_mrd = 1'b1;
      if (port ? bus.ack1 : bus.ack0) begin
        lat  = i;
        err  = port ? bus.err1 : bus.err0;
        rd   = port ? bus.rdata1 : bus.rdata0;
        done = 1'b1;
      end
    end
    if (port) bus.req1 = 1'b0; else bus.req0 = 1'b0;
  endtask

  int          lat, n, mwr_before;
  bit          err, mrd;
  logic [31:0] rd, rd1_at_ack0;
  int          ord [8];
  int          tack [8];

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.adr0 = 0; bus.adr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_ack", {bus.ack1, bus.ack0}, 0);
    check("rst_rdata0", bus.rdata0, 0);
    check("rst_rdata1", bus.rdata1, 0);
    check("rst_mem", {bus.mem_mrd, bus.mem_mwr, bus.mem_adr, bus.mem_d_in}, 0);
    rst = 1'b1;
    @(negedge clk);

    // Port 0 write 0x13 to 0x3E8, observed cycle by cycle
    mwr_before = mwr_cycles;
    bus.req0 = 1; bus.we0 = 1; bus.adr0 = 32'h3E8; bus.wdata0 = 32'h13;
    @(negedge clk);
    bus.req0 = 0;
    check("wr_access_mwr", bus.mem_mwr, 1);
    check("wr_access_mrd", bus.mem_mrd, 0);
    check("wr_access_adr", bus.mem_adr, 32'h3E8);
    check("wr_access_din", bus.mem_d_in, 32'h13);
    check("wr_access_busy", bus.busy, 1);
    @(negedge clk);
    check("wr_resp_mem", {bus.mem_mwr, bus.mem_adr}, 0);
    check("wr_resp_ack", bus.ack0, 0);
    @(negedge clk);
    check("wr_ack0", bus.ack0, 1);
    check("wr_err0", bus.err0, 0);
    check("wr_ack1", bus.ack1, 0);
    check("wr_rdata0_kept", bus.rdata0, 0);
    check("wr_mwr_cycles", mwr_cycles - mwr_before, 1);
    @(negedge clk);
    check("wr_ack0_pulse", bus.ack0, 0);

    // Port 0 read back
    txn(0, 0, 32'h3E8, 0, lat, err, rd, mrd);
    check("rd0_lat", lat, 2);
    check("rd0_data", rd, 32'h13);
    check("rd0_err", err, 0);

    // Port 1 write (leaves last_grant = 1 for the tie test)
    txn(1, 1, 32'h100, 32'hCAFE_F00D, lat, err, rd, mrd);
    check("wr1_lat", lat, 2);

    // Simultaneous reads held until ack: port 0 first, then port 1
    for (int i = 0; i < 8; i++) begin ord[i] = -1; tack[i] = -1; end
    n = 0; rd1_at_ack0 = 32'hX;
    bus.req0 = 1; bus.we0 = 0; bus.adr0 = 32'h3E8;
    bus.req1 = 1; bus.we1 = 0; bus.adr1 = 32'h100;
    for (int i = 0; i < 40 && n < 2; i++) begin
      @(negedge clk);
      if (bus.ack0) begin ord[n] = 0; tack[n] = i; n++; bus.req0 = 0; rd1_at_ack0 = bus.rdata1; end
      if (bus.ack1) begin ord[n] = 1; tack[n] = i; n++; bus.req1 = 0; end
    end
    bus.req0 = 0; bus.req1 = 0;
    check("tie_first", ord[0], 0);
    check("tie_second", ord[1], 1);
    check("tie_t0", tack[0], 2);
    check("tie_t1", tack[1], 5);
    check("tie_rdata1_untouched", rd1_at_ack0, 0);
    check("tie_rdata0", bus.rdata0, 32'h13);
    check("tie_rdata1", bus.rdata1, 32'hCAFE_F00D);

    // Both ports requesting continuously for six transactions
    for (int i = 0; i < 8; i++) ord[i] = -1;
    n = 0;
    bus.req0 = 1; bus.req1 = 1;
    for (int i = 0; i < 60 && n < 6; i++) begin
      @(negedge clk);
      if (bus.ack0) begin ord[n] = 0; n++; end
      if (bus.ack1) begin ord[n] = 1; n++; end
    end
    bus.req0 = 0; bus.req1 = 0;
    for (int i = 0; i < 6; i++) check($sformatf("rr_grant%0d", i), ord[i], i % 2);
    repeat (2) @(negedge clk);
    check("rr_idle_busy", bus.busy, 0);

    // Illegal and boundary addresses on port 1
    txn(1, 0, 32'h3EA, 0, lat, err, rd, mrd);
    check("mis_lat", lat, 1);
    check("mis_err", err, 1);
    check("mis_rdata", rd, 0);
    check("mis_mrd", mrd, 0);
    check("mis_rdata0_kept", bus.rdata0, 32'h13);
    txn(1, 0, 32'hFFFE, 0, lat, err, rd, mrd);
    check("oor_lat", lat, 1);
    check("oor_err", err, 1);
    check("oor_mrd", mrd, 0);
    txn(0, 1, 32'hFFFC, 32'h1234_5678, lat, err, rd, mrd);
    check("top_wr_err", err, 0);
    txn(1, 0, 32'hFFFC, 0, lat, err, rd, mrd);
    check("top_rd_lat", lat, 2);
    check("top_rd_err", err, 0);
    check("top_rd_data", rd, 32'h1234_5678);
    txn(1, 0, 32'h1_0000, 0, lat, err, rd, mrd);
    check("past_end_err", err, 1);
    check("past_end_rdata", rd, 0);
    check("past_end_mrd", mrd, 0);

    // Reset asserted during ACCESS of a write: write lands, no ack
    bus.req0 = 1; bus.we0 = 1; bus.adr0 = 32'h10; bus.wdata0 = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.req0 = 0;
    check("rsta_mwr", bus.mem_mwr, 1);
    rst = 1'b0;
    @(negedge clk);
    check("rsta_busy", bus.busy, 0);
    check("rsta_rdata0", bus.rdata0, 0);
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (bus.ack0) n++; end
    check("rsta_no_ack", n, 0);
    txn(0, 0, 32'h10, 0, lat, err, rd, mrd);
    check("rsta_readback", rd, 32'hDEAD_BEEF);

    // Reset asserted during RESP cancels the ack
    bus.req0 = 1; bus.we0 = 1; bus.adr0 = 32'h20; bus.wdata0 = 32'h55;
    @(negedge clk);
    bus.req0 = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstr_ack", bus.ack0, 0);
    check("rstr_busy", bus.busy, 0);
    rst = 1'b1;
    txn(0, 0, 32'h20, 0, lat, err, rd, mrd);
    check("rstr_readback", rd, 32'h55);

    check("never_dual_ack", dual_ack, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
